alu_self_test_sequencer: RTL and testbench
==========================================

// Module: alu_self_test_sequencer
// PURPOSE
//  Built-in self-test initiator for ArithmeticLogicUnit. Drives a/b/alucontrol from an internal
//  vector table, waits for the ALU to settle, then compares result/zero with the expected values.
//  Reports pass/fail, the fail count and the index of the first failing vector.
//  Sits beside the datapath ALU. It is muxed onto the ALU inputs only while busy=1.
// PARAMETERS
//  WIDTH          32  ALU operand/result width
//  NUM_VECTORS    10  entries in vector ROM (indices 0..NUM_VECTORS-1)
//  SETTLE_CYCLES  1   wait cycles between applying a vector and sampling the result (>=0)
// PORTS
//  clk               in   1                     rising-edge clock
//  reset             in   1                     asynchronous, active-low; 0 = reset
//  start             in   1                     begin a run; sampled only in IDLE
//  abort             in   1                     synchronous; return to IDLE with no done pulse
//  busy              out  1                     run in progress
//  done              out  1                     one-cycle pulse when a run completes
//  pass              out  1                     last completed run had zero mismatches
//  fail_count        out  CW=$clog2(NUM_VECTORS+1)  number of mismatching vectors
//  first_fail        out  IW=$clog2(NUM_VECTORS)    index of first mismatch; valid when fail_count!=0
//  alu_a, alu_b      out  WIDTH                 ALU operands
//  alu_control       out  3                     ALU opcode
//  alu_result        in   WIDTH                 ALU result
//  alu_zero          in   1                     ALU zero flag
// BEHAVIOUR
//  Reset values: all outputs 0 (busy, done, pass, fail_count, first_fail, alu_*), state IDLE, idx 0.
//  FSM states: IDLE -> APPLY -> WAIT -> CHECK -> (APPLY | FIN) -> IDLE.
//  - IDLE: if start=1, clear fail_count/first_fail/pass, set idx=0, go to APPLY. busy=0.
//  - APPLY: register ROM[idx] onto alu_a/alu_b/alu_control. All ALU outputs are registered.
//  - WAIT: stay SETTLE_CYCLES cycles (down-counter). If SETTLE_CYCLES=0, skip WAIT.
//  - CHECK: mismatch = (alu_result!=exp_result)|(alu_zero!=exp_zero).
//    On mismatch: fail_count++; on the first mismatch, capture first_fail=idx.
//    If idx==NUM_VECTORS-1 go to FIN, else idx++ and go to APPLY.
//  - FIN: done=1 for exactly this cycle; busy=0; pass=(fail_count==0); go to IDLE.
//  Timing: busy rises on the cycle after start is sampled. Each vector takes 2+SETTLE_CYCLES cycles.
//    done is asserted 1+NUM_VECTORS*(2+SETTLE_CYCLES) cycles after the start edge (31 at defaults).
//  pass/fail_count/first_fail hold until the next accepted start or reset.
//  alu_* outputs are driven to 0 in IDLE/FIN.
//  start while busy is ignored. start in FIN is ignored; it must be reasserted in IDLE.
//  abort has priority over every transition. In any busy state it goes to IDLE next cycle:
//    no done pulse, pass=0, and fail_count/first_fail keep their partial values.
//  Reset mid-run: all state and outputs are asynchronously forced to reset values; no done pulse.
//  fail_count cannot overflow: CW is sized for NUM_VECTORS.
//  idx never wraps: the last-index test precedes the increment.
// STRUCTURE
//  Shared package alu_pkg (also used by ArithmeticLogicUnit):
//    ALU_AND=3'b111, ALU_OR=3'b110; ALU_CTRL_W=3; vector struct {a,b,ctrl,exp_result,exp_zero}.
//  FSM state enum is local to this module.
//  Sub-module alu_test_vector_rom: combinational idx -> vector. Default contents:
//    0: FFFFFFFF & FFFFFFFF = FFFFFFFF z0   5: FFFFFFFF | FFFFFFFF = FFFFFFFF z0
//    1: 00000000 & FFFFFFFF = 00000000 z1   6: 00000000 | FFFFFFFF = FFFFFFFF z0
//    2: 55555555 & AAAAAAAA = 00000000 z1   7: 00000000 | 00000000 = 00000000 z1
//    3: 00000005 & 00000006 = 00000004 z0   8: 55555555 | AAAAAAAA = FFFFFFFF z0
//    4: 00000000 & 00000000 = 00000000 z1   9: 00000005 | 00000006 = 00000007 z0
// TESTING
//  1 Correct ALU attached, start pulse -> busy 30 cycles, done at +31, pass=1, fail_count=0.
//  2 ALU with result[0] stuck at 0 -> fail_count=5 (vectors 0,5,6,8,9), first_fail=0, pass=0.
//  3 ALU with zero stuck at 0 -> fail_count=4 (vectors 1,2,4,7), first_fail=1, pass=0.
//  4 reset=0 while idx=4, then release and start
//    -> outputs 0 during reset; new run reports pass=1, fail_count=0.
//  5 start held high all run, plus abort at idx=6
//    -> no restart while busy; abort gives IDLE next cycle, done never pulses, pass=0.
//  6 SETTLE_CYCLES=3 with a correct ALU -> done 51 cycles after start; alu_* stable across each check.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alu_pkg
// Description : Opcodes and test-vector record shared by the ALU and its BIST.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_WIDTH  = 32;
    localparam int ALU_CTRL_W = 3;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b111;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b110;

    typedef struct packed {
        logic [ALU_WIDTH-1:0]  a;
        logic [ALU_WIDTH-1:0]  b;
        logic [ALU_CTRL_W-1:0] ctrl;
        logic [ALU_WIDTH-1:0]  exp_result;
        logic                  exp_zero;
    } alu_vec_t;

    function automatic alu_vec_t mk_vec(
        input logic [ALU_WIDTH-1:0]  a,
        input logic [ALU_WIDTH-1:0]  b,
        input logic [ALU_CTRL_W-1:0] ctrl,
        input logic [ALU_WIDTH-1:0]  exp_result,
        input logic                  exp_zero
    );
        alu_vec_t v;
        v.a          = a;
        v.b          = b;
        v.ctrl       = ctrl;
        v.exp_result = exp_result;
        v.exp_zero   = exp_zero;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_test_vector_rom.sv
`default_nettype none
// ============================================================================
// Module      : alu_test_vector_rom
// Description : Combinational index-to-vector table for the ALU self-test.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_test_vector_rom
    import alu_pkg::*;
#(
    parameter int NUM_VECTORS = 10,
    parameter int IW          = 4
) (
    input  logic [IW-1:0] i_idx,
    output alu_vec_t      o_vec
);

    always_comb begin
        o_vec = '0;
        if (int'(i_idx) < NUM_VECTORS) begin
            case (int'(i_idx))
                0: o_vec = mk_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, ALU_AND, 32'hFFFF_FFFF, 1'b0);
                1: o_vec = mk_vec(32'h0000_0000, 32'hFFFF_FFFF, ALU_AND, 32'h0000_0000, 1'b1);
                2: o_vec = mk_vec(32'h5555_5555, 32'hAAAA_AAAA, ALU_AND, 32'h0000_0000, 1'b1);
                3: o_vec = mk_vec(32'h0000_0005, 32'h0000_0006, ALU_AND, 32'h0000_0004, 1'b0);
                4: o_vec = mk_vec(32'h0000_0000, 32'h0000_0000, ALU_AND, 32'h0000_0000, 1'b1);
                5: o_vec = mk_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, ALU_OR,  32'hFFFF_FFFF, 1'b0);
                6: o_vec = mk_vec(32'h0000_0000, 32'hFFFF_FFFF, ALU_OR,  32'hFFFF_FFFF, 1'b0);
                7: o_vec = mk_vec(32'h0000_0000, 32'h0000_0000, ALU_OR,  32'h0000_0000, 1'b1);
                8: o_vec = mk_vec(32'h5555_5555, 32'hAAAA_AAAA, ALU_OR,  32'hFFFF_FFFF, 1'b0);
                9: o_vec = mk_vec(32'h0000_0005, 32'h0000_0006, ALU_OR,  32'h0000_0007, 1'b0);
                default: o_vec = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_self_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_self_test_sequencer
// Description : BIST initiator that steps the ALU through a vector table and
//               reports pass, mismatch count and first failing index.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_self_test_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int NUM_VECTORS   = 10,
    parameter int SETTLE_CYCLES = 1,
    parameter int CW            = $clog2(NUM_VECTORS + 1),
    parameter int IW            = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CW-1:0]         fail_count,
    output logic [IW-1:0]         first_fail,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [ALU_CTRL_W-1:0] alu_control,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic                  alu_zero
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_APPLY = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    localparam int             c_WW        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_WW-1:0] c_WAIT_LOAD = (SETTLE_CYCLES > 0) ? c_WW'(SETTLE_CYCLES - 1) : '0;
    localparam logic [IW-1:0]  c_LAST_IDX  = IW'(NUM_VECTORS - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [IW-1:0]         r_idx;
    logic [c_WW-1:0]       r_wait;
    logic [CW-1:0]         r_fail_count;
    logic [IW-1:0]         r_first_fail;
    logic                  r_pass;
    logic [WIDTH-1:0]      r_alu_a;
    logic [WIDTH-1:0]      r_alu_b;
    logic [ALU_CTRL_W-1:0] r_alu_control;

    alu_vec_t              w_vec;
    logic                  w_busy;
    logic                  w_last;
    logic                  w_mismatch;
    logic [CW-1:0]         w_fail_total;

    alu_test_vector_rom #(
        .NUM_VECTORS (NUM_VECTORS),
        .IW          (IW)
    ) u_rom (
        .i_idx (r_idx),
        .o_vec (w_vec)
    );

    assign w_busy       = (r_state == S_APPLY) || (r_state == S_WAIT) || (r_state == S_CHECK);
    assign w_last       = (r_idx == c_LAST_IDX);
    assign w_mismatch   = (alu_result != WIDTH'(w_vec.exp_result)) || (alu_zero != w_vec.exp_zero);
    assign w_fail_total = w_mismatch ? (r_fail_count + CW'(1)) : r_fail_count;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_APPLY;
            S_APPLY: w_next_state = (SETTLE_CYCLES == 0) ? S_CHECK : S_WAIT;
            S_WAIT:  if (r_wait == '0) w_next_state = S_CHECK;
            S_CHECK: w_next_state = w_last ? S_FIN : S_APPLY;
            S_FIN:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        // Abort overrides whatever the walk would have done this cycle.
        if (abort && w_busy) w_next_state = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_wait        <= '0;
            r_fail_count  <= '0;
            r_first_fail  <= '0;
            r_pass        <= 1'b0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_control <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (w_next_state == S_APPLY) begin
                        r_idx        <= '0;
                        r_fail_count <= '0;
                        r_first_fail <= '0;
                        r_pass       <= 1'b0;
                    end
                end
                S_APPLY: begin
                    r_wait        <= c_WAIT_LOAD;
                    r_alu_a       <= WIDTH'(w_vec.a);
                    r_alu_b       <= WIDTH'(w_vec.b);
                    r_alu_control <= w_vec.ctrl;
                end
                S_WAIT: r_wait <= r_wait - c_WW'(1);
                S_CHECK: begin
                    if (w_next_state != S_IDLE) begin
                        r_fail_count <= w_fail_total;
                        if (w_mismatch && (r_fail_count == '0)) r_first_fail <= r_idx;
                        if (w_next_state == S_FIN) r_pass <= (w_fail_total == '0);
                        else                       r_idx  <= r_idx + IW'(1);
                    end
                end
                default: ;
            endcase
            if (abort && w_busy) r_pass <= 1'b0;
            // The ALU is released back to the datapath whenever we are not walking vectors.
            if ((w_next_state == S_IDLE) || (w_next_state == S_FIN)) begin
                r_alu_a       <= '0;
                r_alu_b       <= '0;
                r_alu_control <= '0;
            end
        end
    end

    assign busy        = w_busy;
    assign done        = (r_state == S_FIN);
    assign pass        = r_pass;
    assign fail_count  = r_fail_count;
    assign first_fail  = r_first_fail;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_control = r_alu_control;

endmodule
`default_nettype wire

// File: tb/tb_alu_self_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_self_test_sequencer
// Description : Self-checking bench for the ALU BIST sequencer with a fault-injectable ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_self_test_sequencer;
    import alu_pkg::*;

    localparam int N  = 10;
    localparam int P1 = 3;
    localparam int P3 = 5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    always #5 clk = ~clk;

    logic        busy1, done1, pass1, z1, busy3, done3, pass3, z3;
    logic [3:0]  fc1, ff1, fc3, ff3;
    logic [31:0] a1, b1, r1, a3, b3, r3;
    logic [2:0]  c1, c3;

    logic [31:0] stuck0 = 32'h0;
    logic [31:0] stuck1 = 32'h0;
    int          zmode  = 0;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] tv_a [N] = '{32'hFFFFFFFF, 32'h0, 32'h55555555, 32'h5, 32'h0,
                              32'hFFFFFFFF, 32'h0, 32'h0, 32'h55555555, 32'h5};
    logic [31:0] tv_b [N] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hAAAAAAAA, 32'h6, 32'h0,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hAAAAAAAA, 32'h6};
    logic [2:0]  tv_c [N] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111,
                              3'b110, 3'b110, 3'b110, 3'b110, 3'b110};
    logic [31:0] tv_r [N] = '{32'hFFFFFFFF, 32'h0, 32'h0, 32'h4, 32'h0,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h7};
    logic        tv_z [N] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    function automatic logic [32:0] alu_eval(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] c, input logic [31:0] s0,
                                             input logic [31:0] s1, input int zm);
        logic [31:0] r;
        logic        z;
        r = (c == 3'b111) ? (a & b) : (c == 3'b110) ? (a | b) : 32'h0;
        r = (r & ~s0) | s1;
        z = (zm == 1) ? 1'b0 : (zm == 2) ? 1'b1 : (r == 32'h0);
        return {z, r};
    endfunction

    assign {z1, r1} = alu_eval(a1, b1, c1, stuck0, stuck1, zmode);
    assign {z3, r3} = alu_eval(a3, b3, c3, 32'h0, 32'h0, 0);

    alu_self_test_sequencer #(.WIDTH(32), .NUM_VECTORS(N), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .busy(busy1), .done(done1), .pass(pass1), .fail_count(fc1), .first_fail(ff1),
        .alu_a(a1), .alu_b(b1), .alu_control(c1), .alu_result(r1), .alu_zero(z1));

    alu_self_test_sequencer #(.WIDTH(32), .NUM_VECTORS(N), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .busy(busy3), .done(done3), .pass(pass3), .fail_count(fc3), .first_fail(ff3),
        .alu_a(a3), .alu_b(b3), .alu_control(c3), .alu_result(r3), .alu_zero(z3));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Operands expected on the ALU bus c cycles after the start edge, for p cycles per vector.
    function automatic logic [66:0] exp_alu(input int c, input int p);
        int k;
        int ph;
        if (c < 1 || c > N * p) return '0;
        k  = (c - 1) / p;
        ph = (c - 1) % p;
        if (ph == 0) begin
            if (k == 0) return '0;
            k = k - 1;
        end
        return {tv_a[k], tv_b[k], tv_c[k]};
    endfunction

    task automatic model_fails(input int nchk, output int cnt, output int first);
        logic [32:0] o;
        cnt   = 0;
        first = 0;
        for (int k = 0; k < nchk; k++) begin
            o = alu_eval(tv_a[k], tv_b[k], tv_c[k], stuck0, stuck1, zmode);
            if (o[31:0] != tv_r[k] || o[32] != tv_z[k]) begin
                if (cnt == 0) first = k;
                cnt++;
            end
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ":busy1"}, busy1, 0);
        chk({tag, ":done1"}, done1, 0);
        chk({tag, ":pass1"}, pass1, 0);
        chk({tag, ":fc1"}, fc1, 0);
        chk({tag, ":ff1"}, ff1, 0);
        chk({tag, ":alu1"}, {a1, b1, c1}, 0);
        chk({tag, ":busy3"}, busy3, 0);
        chk({tag, ":pass3"}, pass3, 0);
        chk({tag, ":fc3"}, fc3, 0);
        chk({tag, ":alu3"}, {a3, b3, c3}, 0);
    endtask

    task automatic run_full(input string tag);
        int ecnt;
        int efirst;
        model_fails(N, ecnt, efirst);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= N * P3 + 3; c++) begin
            chk({tag, ":busy1"}, busy1, c <= N * P1);
            chk({tag, ":done1"}, done1, c == N * P1 + 1);
            chk({tag, ":alu1"}, {a1, b1, c1}, exp_alu(c, P1));
            chk({tag, ":busy3"}, busy3, c <= N * P3);
            chk({tag, ":done3"}, done3, c == N * P3 + 1);
            chk({tag, ":alu3"}, {a3, b3, c3}, exp_alu(c, P3));
            if (c == N * P1 + 1) begin
                chk({tag, ":pass1"}, pass1, ecnt == 0);
                chk({tag, ":fc1"}, fc1, ecnt);
                if (ecnt != 0) chk({tag, ":ff1"}, ff1, efirst);
            end
            if (c == N * P3 + 1) begin
                chk({tag, ":pass3"}, pass3, 1);
                chk({tag, ":fc3"}, fc3, 0);
            end
            @(negedge clk);
        end
        chk({tag, ":pass1_hold"}, pass1, ecnt == 0);
        chk({tag, ":fc1_hold"}, fc1, ecnt);
    endtask

    initial begin
        int ecnt;
        int efirst;

        repeat (3) @(negedge clk);
        check_reset("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset("idle");

        run_full("good");

        stuck0 = 32'h1;
        run_full("res0_stuck");
        chk("res0_stuck:fc_spec", fc1, 5);
        chk("res0_stuck:ff_spec", ff1, 0);
        chk("res0_stuck:pass_spec", pass1, 0);

        stuck0 = 32'h0;
        zmode  = 1;
        run_full("zero_stuck");
        chk("zero_stuck:fc_spec", fc1, 4);
        chk("zero_stuck:ff_spec", ff1, 1);

        for (int i = 0; i < 4; i++) begin
            stuck0 = ($urandom_range(0, 1) == 1) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
            stuck1 = ($urandom_range(0, 2) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
            zmode  = $urandom_range(0, 2);
            run_full($sformatf("rand%0d", i));
        end

        // Reset in the middle of vector 4, then a clean run.
        stuck0 = 32'h0;
        stuck1 = 32'h0;
        zmode  = 0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        chk("midreset:busy_before", busy1, 1);
        chk("midreset:done_before", done1, 0);
        reset = 1'b0;
        #1;
        check_reset("midreset");
        @(negedge clk);
        check_reset("midreset_held");
        reset = 1'b1;
        @(negedge clk);
        run_full("after_reset");

        // Start held for the whole run, abort while vector 6 is settling.
        stuck0 = 32'h1;
        start  = 1'b1;
        @(negedge clk);
        for (int c = 1; c < 20; c++) begin
            chk("hold:busy1", busy1, 1);
            chk("hold:done1", done1, 0);
            chk("hold:alu1", {a1, b1, c1}, exp_alu(c, P1));
            @(negedge clk);
        end
        abort = 1'b1;
        start = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        model_fails((20 - 1) / P1, ecnt, efirst);
        chk("abort:busy1", busy1, 0);
        chk("abort:done1", done1, 0);
        chk("abort:pass1", pass1, 0);
        chk("abort:fc1", fc1, ecnt);
        chk("abort:fc1_spec", fc1, 2);
        chk("abort:ff1", ff1, efirst);
        chk("abort:alu1", {a1, b1, c1}, 0);
        chk("abort:busy3", busy3, 0);
        chk("abort:pass3", pass3, 0);
        for (int c = 0; c < 40; c++) begin
            chk("abort:no_done1", done1, 0);
            chk("abort:no_done3", done3, 0);
            chk("abort:idle1", busy1, 0);
            @(negedge clk);
        end
        chk("abort:fc1_hold", fc1, ecnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
